fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Control FSM and address generator for an in-place radix-2 DIT FFT built on one shared butterfly.
//  Issues one butterfly per cycle over a dual-port sample RAM: read pair, twiddle index, delayed write-back pair.
//  Walks all log2(N) stages, with a hazard drain between stages. Sits between fft_top start/done and the RAM/twiddle ROM.
// PARAMETERS
//  N         16  FFT points; power of 2, >=4. Localparams: LOG2N=$clog2(N), AW=LOG2N, SW=$clog2(LOG2N)+1
//  PIPE_LAT  2   cycles from rd_en to matching wr_en (RAM read + butterfly regs); >=1
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        async active-low reset
//  start      in   1        begin transform; sampled only in IDLE
//  busy       out  1        high from cycle after accepted start until done cycle (exclusive)
//  done       out  1        1-cycle pulse after last write of last stage
//  stage      out  SW       current stage 0..LOG2N-1 (0 in IDLE)
//  rd_en      out  1        read butterfly operands this cycle
//  rd_addr_a  out  AW       operand A address
//  rd_addr_b  out  AW       operand B address (= A + 2^stage)
//  tw_idx     out  AW-1     twiddle ROM index, aligned with rd_en
//  wr_en      out  1        write butterfly sum/diff
//  wr_addr_a  out  AW       sum destination (rd_addr_a delayed PIPE_LAT)
//  wr_addr_b  out  AW       diff destination (rd_addr_b delayed PIPE_LAT)
//  ld_valid   in   1        [FFT_BITREV_LOAD_EN] input sample valid
//  ld_ready   out  1        [FFT_BITREV_LOAD_EN] sequencer accepts sample
//  ld_addr    out  AW       [FFT_BITREV_LOAD_EN] bit-reversed RAM write address for sample
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters and write-delay line cleared. Applies mid-transform, no write completes.
//  FSM: IDLE -start-> [LOAD] -> ISSUE -(k==N/2-1)-> DRAIN -(cnt==PIPE_LAT-1)-> ISSUE (stage+1) or DONE -> IDLE.
//  ISSUE, butterfly k=0..N/2-1 at stage s: half=1<<s; pos=k&(half-1); grp=k>>s;
//    rd_addr_a=(grp<<(s+1))|pos; rd_addr_b=rd_addr_a+half; tw_idx=pos<<(LOG2N-1-s). rd_en=1 every ISSUE cycle.
//  Write path: shift register of {valid,addr_a,addr_b}, depth PIPE_LAT. wr_en at cycle t+PIPE_LAT for each rd_en at t.
//  DRAIN: PIPE_LAT cycles, rd_en=0. Next stage's first read comes 1 cycle after previous stage's last write.
//    The RAM needs no write-first semantics.
//  Last stage DRAIN -> DONE state: done=1, busy=0, 1 cycle, then IDLE. start in DONE cycle ignored; accepted next cycle.
//  Timing, no load phase: start sampled at edge 0; first rd_en in cycle 1.
//    Total = LOG2N*(N/2+PIPE_LAT) cycles; done in cycle 1+that.
//  start while busy: ignored. rd_en and wr_en may both be high in the same cycle (different stages never overlap).
//  stage updates in the first ISSUE cycle of each stage. It holds through DRAIN and returns to 0 in DONE.
// CONFIGURATION
//  FFT_BITREV_LOAD_EN defined:
//    - IDLE -start-> LOAD. ld_ready=1 throughout LOAD; each ld_valid&&ld_ready writes the sample at ld_addr=bitrev(i).
//    - After N handshakes, ISSUE begins the next cycle. ld_valid gaps stall with no timeout.
//    - The RAM write port is muxed by the top level on ld_ready.
//  Undefined: LOAD state absent. ld_* ports do not exist; data must already sit bit-reversed in RAM. start goes straight to ISSUE.
// TESTING
//  N=8,PIPE_LAT=2, start pulse -> stage0 (0,1)(2,3)(4,5)(6,7) tw 0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2;
//    stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
//  Same run -> rd_en cycles 1-4, 7-10, 13-16; wr_en cycles 3-6, 9-12, 15-18, same address pairs; done only at cycle 19.
//  Assert rst_n low at cycle 9 (mid stage1 write) -> wr_en/rd_en/busy 0 immediately.
//    After release, a new start runs a full 18-cycle transform from stage 0.
//  start held high continuously -> back-to-back transforms. Second first rd_en in cycle 21 (start seen at edge 20, post-DONE); no re-trigger while busy.
//  [FFT_BITREV_LOAD_EN] N=8, ld_valid with gap at sample 3 -> ld_addr 0,4,2,6,1,5,3,7 on handshakes only.
//    First rd_en the cycle after 8th handshake.
//  Scoreboard: with behavioural RAM+butterfly, impulse x[0]=1 (N=16) -> all bins equal 1+0j; no RAW violations flagged.

Source files
------------

// File: rtl/fft_seq_if.sv
// Sequencer-side bus of the FFT stage sequencer: start/done, RAM pair ports, twiddle index.
// Optional bit-reversed load port under FFT_BITREV_LOAD_EN.
interface fft_seq_if #(
    parameter int N = 16
);
    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int SW    = $clog2(LOG2N) + 1;

    logic          start;
    logic          busy;
    logic          done;
    logic [SW-1:0] stage;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-2:0] tw_idx;
    logic          wr_en;
    logic [AW-1:0] wr_addr_a;
    logic [AW-1:0] wr_addr_b;
`ifdef FFT_BITREV_LOAD_EN
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
`endif

    modport master (
        input  start,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b
`ifdef FFT_BITREV_LOAD_EN
        , input  ld_valid
        , output ld_ready, ld_addr
`endif
    );

    modport slave (
        output start,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input  wr_en, wr_addr_a, wr_addr_b
`ifdef FFT_BITREV_LOAD_EN
        , output ld_valid
        , input  ld_ready, ld_addr
`endif
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, drain between stages.
// Define FFT_BITREV_LOAD_EN to add a bit-reversed sample load phase before stage 0.
module fft_stage_sequencer #(
    parameter int N        = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    fft_seq_if.master bus
);
    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int SW    = $clog2(LOG2N) + 1;
    localparam int KW    = AW - 1;
    localparam int CW    = $clog2(PIPE_LAT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE
    } state_t;

    state_t        state, state_d;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stage_q;
    logic          k_last, cnt_last, stage_last;
    logic          rd_en_w, busy_w, done_w;
    logic [AW-1:0] kx, half, lmask, addr_a, addr_b;
    logic [AW-1:0] ra, rb;
    logic [KW-1:0] tw;

    logic [PIPE_LAT-1:0] wv;
    logic [AW-1:0]       wa [PIPE_LAT];
    logic [AW-1:0]       wb [PIPE_LAT];

    assign k_last     = (k == KW'(N/2 - 1));
    assign cnt_last   = (cnt == CW'(PIPE_LAT - 1));
    assign stage_last = (stage_q == SW'(LOG2N - 1));

`ifdef FFT_BITREV_LOAD_EN
    logic          ld_ready_w, ld_fire;
    logic [AW-1:0] ld_cnt, ld_rev;

    assign ld_fire = bus.ld_valid && ld_ready_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt <= '0;
        end else if (state == S_IDLE) begin
            ld_cnt <= '0;
        end else if (ld_fire) begin
            ld_cnt <= ld_cnt + AW'(1);
        end
    end

    always_comb begin
        ld_rev = '0;
        for (int i = 0; i < AW; i++) begin
            ld_rev[i] = ld_cnt[AW-1-i];
        end
    end

    assign bus.ld_ready = ld_ready_w;
    assign bus.ld_addr  = ld_ready_w ? ld_rev : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
`ifdef FFT_BITREV_LOAD_EN
                if (bus.start) state_d = S_LOAD;
`else
                if (bus.start) state_d = S_ISSUE;
`endif
            end
`ifdef FFT_BITREV_LOAD_EN
            S_LOAD: begin
                if (ld_fire && ld_cnt == AW'(N - 1)) state_d = S_ISSUE;
            end
`endif
            S_ISSUE: begin
                if (k_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_last) state_d = stage_last ? S_DONE : S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en_w = 1'b0;
        busy_w  = 1'b0;
        done_w  = 1'b0;
`ifdef FFT_BITREV_LOAD_EN
        ld_ready_w = 1'b0;
`endif
        case (state)
`ifdef FFT_BITREV_LOAD_EN
            S_LOAD: begin
                busy_w     = 1'b1;
                ld_ready_w = 1'b1;
            end
`endif
            S_ISSUE: begin
                busy_w  = 1'b1;
                rd_en_w = 1'b1;
            end
            S_DRAIN: busy_w = 1'b1;
            S_DONE:  done_w = 1'b1;
            default: ;
        endcase
    end

    // stage is already the new value in the first ISSUE cycle; DONE resets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            cnt     <= '0;
            stage_q <= '0;
        end else begin
            if (state == S_ISSUE) k <= k_last ? '0 : k + KW'(1);
            if (state == S_DRAIN) cnt <= cnt_last ? '0 : cnt + CW'(1);
            if (state == S_DRAIN && cnt_last) begin
                stage_q <= stage_last ? '0 : stage_q + SW'(1);
            end
        end
    end

    // A is k with a zero inserted at bit s; B sets that bit
    always_comb begin
        kx     = AW'(k);
        half   = AW'(1) << stage_q;
        lmask  = half - AW'(1);
        addr_a = ((kx & ~lmask) << 1) | (kx & lmask);
        addr_b = addr_a + half;
        tw     = KW'(kx & lmask) << (SW'(LOG2N - 1) - stage_q);
    end

    assign ra = rd_en_w ? addr_a : '0;
    assign rb = rd_en_w ? addr_b : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                wa[i] <= '0;
                wb[i] <= '0;
            end
        end else begin
            wv[0] <= rd_en_w;
            wa[0] <= ra;
            wb[0] <= rb;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wv[i] <= wv[i-1];
                wa[i] <= wa[i-1];
                wb[i] <= wb[i-1];
            end
        end
    end

    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
    assign bus.stage     = stage_q;
    assign bus.rd_en     = rd_en_w;
    assign bus.rd_addr_a = ra;
    assign bus.rd_addr_b = rb;
    assign bus.tw_idx    = rd_en_w ? tw : '0;
    assign bus.wr_en     = wv[PIPE_LAT-1];
    assign bus.wr_addr_a = wa[PIPE_LAT-1];
    assign bus.wr_addr_b = wb[PIPE_LAT-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer, N=8, PIPE_LAT=2.
// Expected read/write/done events are queued at start and matched as they appear.
module tb_fft_stage_sequencer;
    localparam int N     = 8;
    localparam int PL    = 2;
    localparam int LOG2N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_seq_if #(.N(N)) bus ();

    fft_stage_sequencer #(.N(N), .PIPE_LAT(PL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    ev_t rq[$];
    ev_t wq[$];
    int  dq[$];
    int  cyc   = 0;
    int  n_chk = 0;
    int  n_err = 0;
    int  c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Group/offset walk: independent of the DUT's bit-insertion form
    task automatic push_xfer(input int base);
        for (int s = 0; s < LOG2N; s++) begin
            int half = 1 << s;
            int span = 2 * half;
            for (int g = 0; g < N / span; g++) begin
                for (int j = 0; j < half; j++) begin
                    int  k = g * half + j;
                    int  rc = base + s * (N / 2 + PL) + k;
                    int  a = g * span + j;
                    ev_t e;
                    e = '{rc, a, a + half, j * (N / span), s};
                    rq.push_back(e);
                    e.cyc = rc + PL;
                    wq.push_back(e);
                end
            end
        end
        dq.push_back(base + LOG2N * (N / 2 + PL));
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (bus.rd_en) begin
                if (rq.size() == 0) begin
                    chk("rd_spurious", 1, 0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_cyc", cyc, e.cyc);
                    chk("rd_a", int'(bus.rd_addr_a), e.a);
                    chk("rd_b", int'(bus.rd_addr_b), e.b);
                    chk("tw", int'(bus.tw_idx), e.tw);
                    chk("stage", int'(bus.stage), e.st);
                    chk("rd_busy", int'(bus.busy), 1);
                end
            end
            if (bus.wr_en) begin
                if (wq.size() == 0) begin
                    chk("wr_spurious", 1, 0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_cyc", cyc, e.cyc);
                    chk("wr_a", int'(bus.wr_addr_a), e.a);
                    chk("wr_b", int'(bus.wr_addr_b), e.b);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    chk("done_spurious", 1, 0);
                end else begin
                    chk("done_cyc", cyc, dq.pop_front());
                    chk("done_busy", int'(bus.busy), 0);
                    chk("done_stage", int'(bus.stage), 0);
                end
            end
        end
    end

    // Returns the edge count of the cycle that holds the first rd_en
    task automatic launch(input bit hold, output int base);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
`ifdef FFT_BITREV_LOAD_EN
        begin
            int rev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
            for (int i = 0; i < N; i++) begin
                if (i == 3) begin
                    @(negedge clk);
                    bus.ld_valid = 1'b0;
                    chk("ld_ready_gap", int'(bus.ld_ready), 1);
                    chk("ld_addr_gap", int'(bus.ld_addr), rev[i]);
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                bus.ld_valid = 1'b1;
                chk("ld_ready", int'(bus.ld_ready), 1);
                chk("ld_addr", int'(bus.ld_addr), rev[i]);
                chk("ld_no_rd", int'(bus.rd_en), 0);
                @(posedge clk);
                #1;
            end
            bus.ld_valid = 1'b0;
        end
`endif
        base = cyc;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((rq.size() + wq.size() + dq.size()) != 0 && n < maxc) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", rq.size() + wq.size() + dq.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
`ifdef FFT_BITREV_LOAD_EN
        bus.ld_valid = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_stage", int'(bus.stage), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        launch(1'b0, c);
        push_xfer(c);
        drain(60);

        launch(1'b0, c);
        push_xfer(c);
        while (cyc < c + 8) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_wr_en", int'(bus.wr_en), 1);
        chk("pre_rst_stage", int'(bus.stage), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", int'(bus.wr_en), 0);
        chk("arst_rd_en", int'(bus.rd_en), 0);
        chk("arst_busy", int'(bus.busy), 0);
        rq.delete();
        wq.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(1'b0, c);
        push_xfer(c);
        drain(60);

`ifndef FFT_BITREV_LOAD_EN
        launch(1'b1, c);
        push_xfer(c);
        push_xfer(c + 20);
        while (cyc < c + 21) @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain(80);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
